// File: rtl/controladora_multi.sv
`default_nettype none
// ============================================================================
//  Module      : controladora_multi
//  Description : Multi-zone lighting controller. Every zone has a debounced
//                push button (short press toggles the lamp or re-triggers the
//                auto timer; long press toggles MANUAL/AUTO mode), a
//                synchronised presence sensor, an auto-shutdown countdown
//                whose last WARN_T cycles dim the lamp with a 50 % PWM, and
//                a shared master-off pulse.
//  Ports       : clk           system clock
//                rst           asynchronous active-high reset
//                push_button   raw, bouncy per-zone buttons (async)
//                infravermelho raw per-zone presence sensors (async)
//                master_off    synchronous pulse, switches every zone off
//                led           registered mode indicator, 1 = AUTO
//                saida         registered lamp drive
//  Revision    : 1.0 - initial release
// ============================================================================
module controladora_multi #(
    parameter int N_CH              = 4,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000,
    parameter int WARN_T            = 3000,
    parameter int PWM_W             = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] push_button,
    input  logic [N_CH-1:0] infravermelho,
    input  logic            master_off,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] saida
);

    localparam int c_DB_W = $clog2(DEBOUNCE_P + 1);
    localparam int c_PR_W = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int c_TM_W = $clog2(AUTO_SHUTDOWN_T + 1);

    localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_P - 1);
    localparam logic [c_DB_W-1:0] c_DB_FIRST = c_DB_W'(1);
    localparam logic [c_PR_W-1:0] c_PR_MAX   = c_PR_W'(SWITCH_MODE_MIN_T);
    localparam logic [c_PR_W-1:0] c_PR_LAST  = c_PR_W'(SWITCH_MODE_MIN_T - 1);
    localparam logic [c_TM_W-1:0] c_TM_LOAD  = c_TM_W'(AUTO_SHUTDOWN_T);
    localparam logic [c_TM_W-1:0] c_TM_WARN  = c_TM_W'(WARN_T);

    // Bit 2 of the encoding marks the AUTO family.
    localparam logic [2:0] c_MAN_OFF   = 3'd0;
    localparam logic [2:0] c_MAN_ON    = 3'd1;
    localparam logic [2:0] c_AUTO_IDLE = 3'd4;
    localparam logic [2:0] c_AUTO_ON   = 3'd5;
    localparam logic [2:0] c_AUTO_WARN = 3'd6;

    logic [N_CH-1:0]  r_pb_s1;
    logic [N_CH-1:0]  r_pb_s2;
    logic [N_CH-1:0]  r_ir_s1;
    logic [N_CH-1:0]  r_ir_s2;
    logic [PWM_W-1:0] r_pwm;

    // Two-flop synchronisers and the shared free-running PWM counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pb_s1 <= '0;
            r_pb_s2 <= '0;
            r_ir_s1 <= '0;
            r_ir_s2 <= '0;
            r_pwm   <= '0;
        end else begin
            r_pb_s1 <= push_button;
            r_pb_s2 <= r_pb_s1;
            r_ir_s1 <= infravermelho;
            r_ir_s2 <= r_ir_s1;
            r_pwm   <= r_pwm + 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic              r_pb_prev;
            logic              r_db_level;
            logic [c_DB_W-1:0] r_db_cnt;
            logic [c_PR_W-1:0] r_pr_cnt;
            logic              r_long;
            logic              r_short;
            logic [2:0]        r_state;
            logic [c_TM_W-1:0] r_timer;
            logic              r_led;
            logic              r_saida;

            logic              w_differs;
            logic              w_changed;
            logic              w_db_update;
            logic              w_db_fall;
            logic              w_trigger;
            logic [c_TM_W-1:0] w_dec;

            assign w_differs   = (r_pb_s2[i] != r_db_level);
            assign w_changed   = (r_pb_s2[i] != r_pb_prev);
            // A fresh change counts as the first stable cycle; the level
            // flips on the DEBOUNCE_P-th consecutive stable sample.
            assign w_db_update = w_differs &&
                                 (w_changed ? (DEBOUNCE_P == 1) : (r_db_cnt >= c_DB_LAST));
            assign w_db_fall   = w_db_update && r_db_level;
            assign w_trigger   = r_short || r_ir_s2[i];
            assign w_dec       = (r_timer != '0) ? (r_timer - 1'b1) : '0;

            // Debounce and press classification.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pb_prev  <= 1'b0;
                    r_db_level <= 1'b0;
                    r_db_cnt   <= '0;
                    r_pr_cnt   <= '0;
                    r_long     <= 1'b0;
                    r_short    <= 1'b0;
                end else begin
                    r_pb_prev <= r_pb_s2[i];
                    if (!w_differs || w_db_update) begin
                        r_db_cnt <= '0;
                    end else if (w_changed) begin
                        r_db_cnt <= c_DB_FIRST;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    if (w_db_update) begin
                        r_db_level <= r_pb_s2[i];
                    end

                    if (!r_db_level || w_db_fall) begin
                        r_pr_cnt <= '0;
                    end else if (r_pr_cnt != c_PR_MAX) begin
                        r_pr_cnt <= r_pr_cnt + 1'b1;
                    end
                    // Long fires only on the step into saturation, so once per press.
                    r_long  <= r_db_level && !w_db_fall && (r_pr_cnt == c_PR_LAST);
                    r_short <= w_db_fall && (r_pr_cnt != c_PR_MAX);
                end
            end

            // Zone state machine: master_off > LONG > SHORT > IR > timer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= c_MAN_OFF;
                    r_timer <= '0;
                end else if (master_off) begin
                    r_state <= r_state[2] ? c_AUTO_IDLE : c_MAN_OFF;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        c_MAN_OFF: begin
                            if (r_long)       r_state <= c_AUTO_IDLE;
                            else if (r_short) r_state <= c_MAN_ON;
                        end
                        c_MAN_ON: begin
                            if (r_long)       r_state <= c_AUTO_IDLE;
                            else if (r_short) r_state <= c_MAN_OFF;
                        end
                        c_AUTO_IDLE: begin
                            if (r_long) begin
                                r_state <= c_MAN_OFF;
                            end else if (w_trigger) begin
                                r_state <= c_AUTO_ON;
                                r_timer <= c_TM_LOAD;
                            end
                        end
                        c_AUTO_ON, c_AUTO_WARN: begin
                            if (r_long) begin
                                r_state <= c_MAN_OFF;
                                r_timer <= '0;
                            end else if (w_trigger) begin
                                r_state <= c_AUTO_ON;
                                r_timer <= c_TM_LOAD;
                            end else begin
                                // Transitions key on the value being written, so the
                                // lamp is lit for exactly AUTO_SHUTDOWN_T cycles.
                                r_timer <= w_dec;
                                if (r_state == c_AUTO_ON && w_dec == c_TM_WARN) begin
                                    r_state <= c_AUTO_WARN;
                                end else if (r_state == c_AUTO_WARN && w_dec == '0) begin
                                    r_state <= c_AUTO_IDLE;
                                end
                            end
                        end
                        default: begin
                            r_state <= c_MAN_OFF;
                            r_timer <= '0;
                        end
                    endcase
                end
            end

            // Registered outputs, one cycle behind the state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_led   <= 1'b0;
                    r_saida <= 1'b0;
                end else begin
                    r_led <= r_state[2];
                    case (r_state)
                        c_MAN_ON, c_AUTO_ON: r_saida <= 1'b1;
                        c_AUTO_WARN:         r_saida <= ~r_pwm[PWM_W-1];
                        default:             r_saida <= 1'b0;
                    endcase
                end
            end

            assign led[i]   = r_led;
            assign saida[i] = r_saida;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_controladora_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controladora_multi
//  Description : Directed self-checking bench for controladora_multi with
//                small parameters (2 zones, short debounce and timers).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controladora_multi;

    localparam int N_CH              = 2;
    localparam int DEBOUNCE_P        = 4;
    localparam int SWITCH_MODE_MIN_T = 20;
    localparam int AUTO_SHUTDOWN_T   = 50;
    localparam int WARN_T            = 10;
    localparam int PWM_W             = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] pb  = '0;
    logic [N_CH-1:0] ir  = '0;
    logic            mo  = 1'b0;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] saida;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc;

    always #5 clk = ~clk;

    // Edges since the last reset release; the shared PWM counter equals cyc mod 8.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    controladora_multi #(
        .N_CH              (N_CH),
        .DEBOUNCE_P        (DEBOUNCE_P),
        .SWITCH_MODE_MIN_T (SWITCH_MODE_MIN_T),
        .AUTO_SHUTDOWN_T   (AUTO_SHUTDOWN_T),
        .WARN_T            (WARN_T),
        .PWM_W             (PWM_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_button   (pb),
        .infravermelho (ir),
        .master_off    (mo),
        .led           (led),
        .saida         (saida)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int ch, input int n);
        pb[ch] = 1'b1;
        tick(n);
        pb[ch] = 1'b0;
    endtask

    // Called right after the edge that loads the ch1 timer with 50.
    task automatic check_countdown(input string tag);
        logic exp_pwm;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk({tag, "_solid"}, 8'(saida[1]), 8'd1);
        end
        for (int k = 41; k <= 50; k++) begin
            tick();
            // Output at edge n reflects the PWM value held before edge n.
            exp_pwm = (((cyc - 1) % 8) < 4);
            chk({tag, "_warn_pwm"}, 8'(saida[1]), 8'(exp_pwm));
            chk({tag, "_warn_led"}, 8'(led[1]), 8'd1);
        end
        tick();
        chk({tag, "_off"}, 8'(saida[1]), 8'd0);
        chk({tag, "_idle_led"}, 8'(led[1]), 8'd1);
    endtask

    initial begin
        // Reset state.
        tick(3);
        chk("reset_led", 8'(led), 8'd0);
        chk("reset_saida", 8'(saida), 8'd0);
        rst = 1'b0;

        // Reset in the middle of a press discards it.
        pb[0] = 1'b1;
        tick(10);
        rst = 1'b1;
        pb[0] = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("rst_discard_saida", 8'(saida), 8'd0);
        chk("rst_discard_led", 8'(led), 8'd0);

        // 1. Clean short presses toggle ch0 manually.
        press(0, 8);
        tick(20);
        chk("short_on_saida", 8'(saida), 8'b01);
        chk("short_on_led", 8'(led), 8'b00);
        press(0, 8);
        tick(20);
        chk("short_off_saida", 8'(saida), 8'b00);

        // 2. Bounce shorter than the debounce window produces nothing.
        repeat (5) begin
            pb[0] = 1'b1;
            tick(3);
            pb[0] = 1'b0;
            tick(3);
        end
        tick(20);
        chk("bounce_saida", 8'(saida), 8'b00);
        chk("bounce_led", 8'(led), 8'b00);

        // 3. Long press on ch1: led rises exactly 2+4+20+2 cycles after the edge.
        pb[1] = 1'b1;
        tick(27);
        chk("long_before", 8'(led[1]), 8'd0);
        tick();
        chk("long_at", 8'(led[1]), 8'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("long_hold", 8'(led[1]), 8'd1);
        end
        pb[1] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("long_release_led", 8'(led[1]), 8'd1);
            chk("long_release_saida", 8'(saida[1]), 8'd0);
        end

        // 4. One-cycle IR pulse: 40 solid, 10 dimmed, then idle.
        ir[1] = 1'b1;
        tick();
        ir[1] = 1'b0;
        tick(2);
        check_countdown("ir_pulse");

        // IR during the warning phase restores a full reload.
        ir[1] = 1'b1;
        tick();
        ir[1] = 1'b0;
        tick(2);
        tick(43);
        ir[1] = 1'b1;
        tick();
        ir[1] = 1'b0;
        tick(2);
        check_countdown("warn_reload");

        // 5. master_off with ch0 MAN_ON and ch1 AUTO_ON.
        press(0, 8);
        tick(10);
        ir[1] = 1'b1;
        tick();
        ir[1] = 1'b0;
        tick(3);
        chk("pre_master_saida", 8'(saida), 8'b11);
        chk("pre_master_led", 8'(led), 8'b10);
        mo = 1'b1;
        tick();
        mo = 1'b0;
        tick();
        chk("master_saida", 8'(saida), 8'b00);
        chk("master_led", 8'(led), 8'b10);

        // SHORT on ch0 coinciding with master_off is dropped.
        press(0, 8);
        tick(6);
        mo = 1'b1;
        tick();
        mo = 1'b0;
        tick(5);
        chk("master_vs_short_saida", 8'(saida), 8'b00);
        chk("master_vs_short_led", 8'(led), 8'b10);

        // IR held through master_off relights on the following cycle.
        ir[1] = 1'b1;
        tick(4);
        mo = 1'b1;
        tick();
        mo = 1'b0;
        tick();
        chk("master_ir_idle", 8'(saida[1]), 8'd0);
        tick();
        chk("master_ir_relit", 8'(saida[1]), 8'd1);
        ir[1] = 1'b0;

        // 6. Asynchronous reset while ch1 is in the warning phase.
        tick(45);
        chk("pre_async_led", 8'(led[1]), 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", 8'(led), 8'd0);
        chk("async_rst_saida", 8'(saida), 8'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("post_rst_led", 8'(led), 8'd0);
        chk("post_rst_saida", 8'(saida), 8'd0);
        press(1, 8);
        tick(10);
        chk("post_rst_man_on_saida", 8'(saida), 8'b10);
        chk("post_rst_man_on_led", 8'(led), 8'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
